// File: rtl/pic8259_pkg.sv
// pic8259_pkg: constants and types shared by the interrupt request, ISR and
// priority blocks of the 8259-style interrupt controller.
package pic8259_pkg;

  // Default number of interrupt request channels (IR0..IR7).
  localparam int NUM_IRQ_DEFAULT = 8;

  // One bit per interrupt channel.
  typedef logic [NUM_IRQ_DEFAULT-1:0] irq_vec_t;

  // Global trigger mode selected by the ICW1 LTIM bit.
  typedef enum logic {
    TRIG_EDGE  = 1'b0,
    TRIG_LEVEL = 1'b1
  } trig_mode_t;

endpackage : pic8259_pkg

// File: rtl/irq_channel.sv
// irq_channel: one interrupt request channel -- optional two-flop pin
// synchronizer, edge-arm latch and the IRR bit.
// Optional feature: define IRQ_PIN_SYNC_EN to insert the pin synchronizer
// (pin-to-IRR latency 3 clocks instead of 1).
module irq_channel
  import pic8259_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic icw1_reset,
  input  logic level_mode,
  input  logic freeze,
  input  logic clear,
  input  logic pin,
  output logic irr
);

  logic       w_pin;
  logic       w_edge_event;
  trig_mode_t w_mode;
  logic       r_arm;
  logic       r_irr;

`ifdef IRQ_PIN_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer for the asynchronous device pin; cleared only by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pin};
    end
  end

  assign w_pin = r_sync[1];
`else
  assign w_pin = pin;
`endif

  assign w_mode       = trig_mode_t'(level_mode);
  assign w_edge_event = w_pin & r_arm;

  // Edge-arm latch: armed while the pin is seen low, disarmed by any clear so
  // a pin still held high cannot re-request until it goes low again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_arm <= 1'b0;
    end else if (icw1_reset || clear) begin
      r_arm <= 1'b0;
    end else if (!w_pin) begin
      r_arm <= 1'b1;
    end
  end

  // IRR bit: ICW1 clear, channel clear, freeze hold, then mode-dependent update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_irr <= 1'b0;
    end else if (icw1_reset) begin
      r_irr <= 1'b0;
    end else if (clear) begin
      r_irr <= 1'b0;
    end else if (freeze) begin
      r_irr <= r_irr;
    end else if (w_mode == TRIG_LEVEL) begin
      r_irr <= w_pin;
    end else if (w_edge_event) begin
      r_irr <= 1'b1;
    end
  end

  assign irr = r_irr;

endmodule : irq_channel

// File: rtl/interrupt_request.sv
// interrupt_request: interrupt request register (IRR) of an 8259-style PIC,
// built from NUM_IRQ independent irq_channel instances sharing mode, freeze
// and reset controls.
// Optional feature: define IRQ_PIN_SYNC_EN to synchronize the request pins
// (two flops per channel, pin-to-IRR latency 3 clocks).
module interrupt_request
  import pic8259_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               write_initial_command_word_1_reset,
  input  logic               level_triggered_config,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_request,
  input  logic [NUM_IRQ-1:0] interrupt_request_pin,
  output logic [NUM_IRQ-1:0] interrupt_request_register
);

  logic [NUM_IRQ-1:0] w_irr;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_channel
    irq_channel u_channel (
      .clock      (clock),
      .reset_n    (reset_n),
      .icw1_reset (write_initial_command_word_1_reset),
      .level_mode (level_triggered_config),
      .freeze     (freeze),
      .clear      (clear_interrupt_request[gi]),
      .pin        (interrupt_request_pin[gi]),
      .irr        (w_irr[gi])
    );
  end

  assign interrupt_request_register = w_irr;

endmodule : interrupt_request

// File: tb/tb_interrupt_request.sv
// tb_interrupt_request: directed scoreboard bench for interrupt_request
// (NUM_IRQ=8, pin synchronizer disabled).
module tb_interrupt_request;
  import pic8259_pkg::*;

  logic     clock = 1'b0;
  logic     reset_n;
  logic     icw1;
  logic     lvl;
  logic     frz;
  irq_vec_t clr;
  irq_vec_t pin;
  irq_vec_t irr;

  int       n_cmp = 0;
  int       n_mis = 0;
  irq_vec_t exp_q[$];

  interrupt_request #(.NUM_IRQ(8)) dut (
    .clock                              (clock),
    .reset_n                            (reset_n),
    .write_initial_command_word_1_reset (icw1),
    .level_triggered_config             (lvl),
    .freeze                             (frz),
    .clear_interrupt_request            (clr),
    .interrupt_request_pin              (pin),
    .interrupt_request_register         (irr)
  );

  always #5 clock = ~clock;

  // Compare the current IRR against the oldest expected value in the scoreboard.
  task automatic check_out(input string tag);
    irq_vec_t exp_v;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, irr);
    end else begin
      exp_v = exp_q.pop_front();
      assert (irr === exp_v) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", tag, irr, exp_v);
      end
    end
    $display("[%0t] %-14s pin=%h clr=%h lvl=%0b frz=%0b icw1=%0b irr=%h",
             $time, tag, pin, clr, lvl, frz, icw1, irr);
  endtask

  // Apply inputs, push expected IRR, advance one clock and check just after the edge.
  task automatic step(input irq_vec_t p, input irq_vec_t c, input logic l,
                      input logic f, input logic i, input irq_vec_t e,
                      input string tag);
    pin  = p;
    clr  = c;
    lvl  = l;
    frz  = f;
    icw1 = i;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with all pins high: IRR must clear without a clock edge.
    reset_n = 1'b0;
    pin = 8'hFF; clr = 8'h00; lvl = 1'b0; frz = 1'b0; icw1 = 1'b0;
    #2;
    exp_q.push_back(8'h00);
    check_out("rst_async");
    @(posedge clock); #1;
    exp_q.push_back(8'h00);
    check_out("rst_held");
    reset_n = 1'b1;

    // Latches are 0 after reset: pins held high in edge mode cannot set.
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "rst_noarm0");
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "rst_noarm1");

    // Level mode: follow pin, clear wins while held, pin low drops IRR.
    step(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, "lvl_set");
    step(8'h04, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00, "lvl_clr");
    step(8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, "lvl_reset");
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "lvl_drop");

    // Edge mode: one set per rising edge, clear with pin high stays clear.
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "edge_low");
    step(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h80, "edge_rise");
    step(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h80, "edge_hold");
    step(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, "edge_clr");
    step(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "edge_stay0");
    step(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "edge_stay1");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "edge_rearm");
    step(8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h80, "edge_rise2");
    step(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, "edge_clr2");

    // Freeze: pin activity held off, armed edge captured after release.
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "frz_prep0");
    step(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, "frz_prep1");
    step(8'h21, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, "frz_edge");
    step(8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, "frz_level");
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, "frz_edge2");
    step(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h21, "frz_release");
    step(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, "frz_clr");
    step(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "frz_disarmed");

    // Mode switch keeps existing IRR contents.
    step(8'h0C, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0C, "mode_lvl");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0C, "mode_to_edge");

    // ICW1 reset: full clear, then no set until pins go low and rise.
    step(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, "icw1_prep");
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "icw1_clr");
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "icw1_noset0");
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "icw1_noset1");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "icw1_low");
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, "icw1_rise");

    // Simultaneous rising edge and clear on channel 1 resolves to clear.
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "sim_prep0");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "sim_prep1");
    step(8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, "sim_clr_edge");
    step(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "sim_disarmed");
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "sim_low");
    step(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, "sim_rise");

    // Asynchronous reset mid-cycle with IRR set.
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    check_out("rst_midcycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_interrupt_request

// File: doc/interrupt_request.md
INTERRUPT_REQUEST -- requirements
Module: interrupt_request

Interface
REQ-001 The module SHALL have parameter NUM_IRQ, default 8, meaning the number of interrupt request channels; all vectors below are NUM_IRQ bits wide.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port write_initial_command_word_1_reset, input, 1 bit: synchronous active-high clear issued on an ICW1 write.
REQ-005 The module SHALL have port level_triggered_config, input, 1 bit: 1 selects level-triggered mode and 0 selects edge-triggered mode, global to all channels.
REQ-006 The module SHALL have port freeze, input, 1 bit: 1 holds the request register against new pin activity (INTA sequence in progress).
REQ-007 The module SHALL have port clear_interrupt_request, input, NUM_IRQ bits: a per-channel synchronous clear.
REQ-008 The module SHALL have port interrupt_request_pin, input, NUM_IRQ bits: the IR0..IR7 device pins, active-high.
REQ-009 The module SHALL have port interrupt_request_register, output, NUM_IRQ bits: the IRR, driven directly from flops.

Function
REQ-010 Each channel SHALL hold an edge-arm latch, set to 1 on a clock edge where its pin is 0, and cleared by write_initial_command_word_1_reset or by its clear_interrupt_request bit.
REQ-011 A channel SHALL see an edge event when its pin is 1 and its edge-arm latch is 1.
REQ-012 The IRR bit update priority per clock SHALL be: (1) write_initial_command_word_1_reset -> 0; (2) clear_interrupt_request[i] -> 0; (3) freeze=1 -> hold; (4) level mode -> IRR[i] = pin[i]; (5) edge mode with an edge event -> 1; (6) otherwise hold.
REQ-013 Latency from a pin change to the IRR SHALL be exactly 1 clock; clear and ICW1 reset also SHALL take effect at the next edge.
REQ-014 In edge mode, a pin held high SHALL produce exactly one IRR set; after a clear, the IRR SHALL not set again until the pin returns low for at least one clock and then rises.
REQ-015 In level mode, the IRR SHALL follow the pin, so deasserting the pin drops the IRR one clock later.
REQ-016 A clear and a rising edge on the same channel in the same cycle SHALL resolve to the clear (IRR=0, latch disarmed).
REQ-017 Releasing freeze SHALL resume normal evaluation on the next clock; an edge that arrived during freeze SHALL be captured after release only if its latch is still armed.
REQ-018 Switching level_triggered_config SHALL take effect on the next clock without altering the existing IRR contents.
REQ-019 Channels SHALL be fully independent except for the shared mode, freeze and reset signals.

Reset
REQ-020 Asserting reset_n=0 SHALL asynchronously force the IRR and all edge-arm latches to 0.
REQ-021 After release, reset_n SHALL be synchronously deasserted externally; the block SHALL require no further initialisation.
REQ-022 write_initial_command_word_1_reset SHALL give the same end state as reset_n, but synchronously.

Configuration
REQ-023 With macro IRQ_PIN_SYNC_EN defined, interrupt_request_pin SHALL pass through a two-flop synchronizer per channel before edge and level logic, with pin-to-IRR latency of 3 clocks; synchronizer flops SHALL reset to 0 through reset_n only.
REQ-024 Without IRQ_PIN_SYNC_EN, pins SHALL be used directly with 1-clock latency, and no synchronizer flops SHALL exist.

Structure
REQ-025 Package pic8259_pkg SHALL hold the NUM_IRQ default constant and the irq-vector typedef, shared with the ISR and priority blocks.
REQ-026 Per-channel logic (sync, edge-arm latch, IRR bit) SHALL be one sub-module irq_channel, instantiated NUM_IRQ times via generate.

Verification (macro off, NUM_IRQ=8)
REQ-027 The bench SHALL cover: reset_n=0 with pins=0xFF -> IRR=0x00 immediately, latches 0.
REQ-028 The bench SHALL cover: level mode, pin=0x04 -> IRR=0x04 next clock; clear=0x04 while the pin is held -> IRR=0x00 that clock, then 0x04 again after clear drops; pin=0x00 -> IRR=0x00.
REQ-029 The bench SHALL cover: edge mode, pin 0x00 then 0x80 -> IRR=0x80; clear=0x80 with the pin still high -> IRR=0x00 and it stays 0x00.
REQ-030 The bench SHALL cover: freeze=1, then an edge on pin 0x01 in edge mode or level pin=0x10 -> IRR unchanged; clear=0xFF during freeze -> IRR=0x00.
REQ-031 The bench SHALL cover: write_initial_command_word_1_reset=1 with IRR=0xFF -> IRR=0x00 next clock; a pin still high in edge mode -> no set until it goes low and then high.
REQ-032 The bench SHALL cover: a simultaneous rising edge on pin 0x02 and clear=0x02 -> IRR bit1=0.
